// File: rtl/upht_upd_ctrl.sv
`ifndef SAT_TABLE_SIZE
`define SAT_TABLE_SIZE 64
`endif

// Show-ahead queue: pushed entry visible at head one edge later; flush empties at the next edge.
// Backpressure: full refuses a push, even in a cycle that also pops.
module upht_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push_vld,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_acc;
  logic             pop_acc;

  assign count    = wr_ptr - rd_ptr;
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (count == (AW+1)'(DEPTH));
  assign head_dat = mem[rd_ptr[AW-1:0]];
  assign push_acc = push_vld && !full && !flush;
  assign pop_acc  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_acc)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// uPHT commit-update controller: queue -> read (RD) -> saturating write (WR), min 2 cycles per update.
// Predictor reads win the shared read port until the starve limit forces the queued update through.
module upht_upd_ctrl #(
  parameter int IDX_W      = $clog2(`SAT_TABLE_SIZE),
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_LIM = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_upd_vld,
  output logic             o_upd_rdy,
  input  logic [IDX_W-1:0] i_upd_idx,
  input  logic             i_upd_taken,
  input  logic             i_pred_vld,
  input  logic [IDX_W-1:0] i_pred_idx,
  output logic             o_pred_gnt,
  output logic [1:0]       o_pred_cnt,
  input  logic             i_flush,
  output logic             o_uPhtRead_vld,
  output logic [IDX_W-1:0] o_uPhtRd_addr,
  input  logic [1:0]       i_uPhtRd_Cnt,
  output logic             o_uPhtWrite_vld,
  output logic [IDX_W-1:0] o_uPhtWr_addr,
  output logic [1:0]       o_commit_Cnt,
  output logic             o_uPht_enable,
  output logic             o_busy
);
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } upd_t;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [SW-1:0]    starve_cnt;
  logic [SW-1:0]    starve_nxt;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] wr_idx_nxt;
  logic [1:0]       wr_cnt;
  logic [1:0]       wr_cnt_nxt;
  upd_t             push_dat;
  upd_t             head_dat;
  logic             q_full;
  logic             q_empty;
  logic [CW-1:0]    q_count;
  logic             push_acc;
  logic             force_upd;
  logic             blocked;

  function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
    if (taken) return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
    else       return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
  endfunction

  assign push_dat  = '{idx: i_upd_idx, taken: i_upd_taken};
  assign push_acc  = i_upd_vld && !q_full && !i_flush;
  assign force_upd = (starve_cnt == SW'(STARVE_LIM));
  assign blocked   = i_pred_vld && !force_upd;

  upht_fifo #(
    .WIDTH ($bits(upd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_queue (
    .clk      (i_clk),
    .rst_n    (i_rstn),
    .flush    (i_flush),
    .push_vld (i_upd_vld),
    .push_dat (push_dat),
    .pop      (state == WR),
    .head_dat (head_dat),
    .full     (q_full),
    .empty    (q_empty),
    .count    (q_count)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      starve_cnt <= '0;
      wr_idx     <= '0;
      wr_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      starve_cnt <= starve_nxt;
      wr_idx     <= wr_idx_nxt;
      wr_cnt     <= wr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    starve_nxt = starve_cnt;
    wr_idx_nxt = wr_idx;
    wr_cnt_nxt = wr_cnt;
    case (state)
      IDLE: if (!q_empty) state_nxt = RD;
      RD: begin
        // blocked already implies starve_cnt < STARVE_LIM, so the increment saturates by construction
        if (blocked) begin
          starve_nxt = starve_cnt + SW'(1);
        end else begin
          state_nxt  = WR;
          wr_idx_nxt = head_dat.idx;
          wr_cnt_nxt = sat_next(i_uPhtRd_Cnt, head_dat.taken);
          starve_nxt = '0;
        end
      end
      WR: state_nxt = ((q_count > CW'(1)) || push_acc) ? RD : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (i_flush) begin
      state_nxt  = IDLE;
      starve_nxt = '0;
    end
  end

  always_comb begin
    o_uPhtRd_addr = '0;
    if (o_pred_gnt)       o_uPhtRd_addr = i_pred_idx;
    else if (state == RD) o_uPhtRd_addr = head_dat.idx;
  end

  assign o_upd_rdy       = !q_full;
  assign o_pred_gnt      = i_pred_vld && !((state == RD) && force_upd);
  assign o_pred_cnt      = i_uPhtRd_Cnt;
  assign o_uPhtRead_vld  = o_pred_gnt || (state == RD);
  assign o_uPhtWrite_vld = (state == WR);
  assign o_uPht_enable   = (state == WR);
  assign o_uPhtWr_addr   = wr_idx;
  assign o_commit_Cnt    = wr_cnt;
  assign o_busy          = (state != IDLE) || !q_empty;
endmodule

// File: tb/tb_upht_upd_ctrl.sv
// Directed bench for upht_upd_ctrl with a small behavioural uPHT array on the read/write ports.
module tb_upht_upd_ctrl;
  localparam int IDX_W = 6;

  logic             i_clk = 1'b0;
  logic             i_rstn;
  logic             i_upd_vld;
  logic             o_upd_rdy;
  logic [IDX_W-1:0] i_upd_idx;
  logic             i_upd_taken;
  logic             i_pred_vld;
  logic [IDX_W-1:0] i_pred_idx;
  logic             o_pred_gnt;
  logic [1:0]       o_pred_cnt;
  logic             i_flush;
  logic             o_uPhtRead_vld;
  logic [IDX_W-1:0] o_uPhtRd_addr;
  logic [1:0]       i_uPhtRd_Cnt;
  logic             o_uPhtWrite_vld;
  logic [IDX_W-1:0] o_uPhtWr_addr;
  logic [1:0]       o_commit_Cnt;
  logic             o_uPht_enable;
  logic             o_busy;

  logic             ld_vld;
  logic [IDX_W-1:0] ld_idx;
  logic [1:0]       ld_cnt;
  logic [1:0]       pht [64];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  upht_upd_ctrl #(
    .IDX_W      (IDX_W),
    .FIFO_DEPTH (4),
    .STARVE_LIM (8)
  ) dut (
    .i_clk           (i_clk),
    .i_rstn          (i_rstn),
    .i_upd_vld       (i_upd_vld),
    .o_upd_rdy       (o_upd_rdy),
    .i_upd_idx       (i_upd_idx),
    .i_upd_taken     (i_upd_taken),
    .i_pred_vld      (i_pred_vld),
    .i_pred_idx      (i_pred_idx),
    .o_pred_gnt      (o_pred_gnt),
    .o_pred_cnt      (o_pred_cnt),
    .i_flush         (i_flush),
    .o_uPhtRead_vld  (o_uPhtRead_vld),
    .o_uPhtRd_addr   (o_uPhtRd_addr),
    .i_uPhtRd_Cnt    (i_uPhtRd_Cnt),
    .o_uPhtWrite_vld (o_uPhtWrite_vld),
    .o_uPhtWr_addr   (o_uPhtWr_addr),
    .o_commit_Cnt    (o_commit_Cnt),
    .o_uPht_enable   (o_uPht_enable),
    .o_busy          (o_busy)
  );

  // uPHT table: resets to weakly-taken, takes DUT writes, plus a bench preload port
  always @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      for (int i = 0; i < 64; i++) pht[i] <= 2'b10;
    end else if (o_uPhtWrite_vld) begin
      pht[o_uPhtWr_addr] <= o_commit_Cnt;
    end else if (ld_vld) begin
      pht[ld_idx] <= ld_cnt;
    end
  end
  assign i_uPhtRd_Cnt = pht[o_uPhtRd_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input int idx, input logic taken);
    i_upd_vld   = 1'b1;
    i_upd_idx   = IDX_W'(idx);
    i_upd_taken = taken;
    tick();
    i_upd_vld   = 1'b0;
  endtask

  task automatic preload(input int idx, input logic [1:0] cnt);
    ld_vld = 1'b1;
    ld_idx = IDX_W'(idx);
    ld_cnt = cnt;
    tick();
    ld_vld = 1'b0;
  endtask

  initial begin
    i_rstn = 1'b0; i_upd_vld = 1'b0; i_upd_idx = '0; i_upd_taken = 1'b0;
    i_pred_vld = 1'b1; i_pred_idx = '0; i_flush = 1'b0;
    ld_vld = 1'b0; ld_idx = '0; ld_cnt = '0;

    // reset values
    #12;
    check("rst_rdy",  32'(o_upd_rdy), 32'd1);
    check("rst_wvld", 32'(o_uPhtWrite_vld), 32'd0);
    check("rst_en",   32'(o_uPht_enable), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_gnt1", 32'(o_pred_gnt), 32'd1);
    i_pred_vld = 1'b0;
    #1;
    check("rst_gnt0", 32'(o_pred_gnt), 32'd0);
    @(posedge i_clk); #1; i_rstn = 1'b1;
    tick();

    // single update idx 5 taken, counter 2 -> 3
    push(5, 1'b1);
    @(negedge i_clk);
    check("t1_k0_busy", 32'(o_busy), 32'd1);
    check("t1_k0_rvld", 32'(o_uPhtRead_vld), 32'd0);
    tick(); @(negedge i_clk);
    check("t1_rd_vld",  32'(o_uPhtRead_vld), 32'd1);
    check("t1_rd_addr", 32'(o_uPhtRd_addr), 32'd5);
    check("t1_rd_wvld", 32'(o_uPhtWrite_vld), 32'd0);
    tick(); @(negedge i_clk);
    check("t1_wr_vld",  32'(o_uPhtWrite_vld), 32'd1);
    check("t1_wr_en",   32'(o_uPht_enable), 32'd1);
    check("t1_wr_addr", 32'(o_uPhtWr_addr), 32'd5);
    check("t1_wr_cnt",  32'(o_commit_Cnt), 32'd3);
    tick(); @(negedge i_clk);
    check("t1_idle_wvld", 32'(o_uPhtWrite_vld), 32'd0);
    check("t1_idle_busy", 32'(o_busy), 32'd0);
    tick();

    // saturation at both ends
    preload(3, 2'b11);
    push(3, 1'b1);
    tick(); tick(); @(negedge i_clk);
    check("t2_sat_hi", 32'(o_commit_Cnt), 32'd3);
    check("t2_hi_wvld", 32'(o_uPhtWrite_vld), 32'd1);
    tick();
    preload(3, 2'b00);
    push(3, 1'b0);
    tick(); tick(); @(negedge i_clk);
    check("t2_sat_lo", 32'(o_commit_Cnt), 32'd0);
    check("t2_lo_addr", 32'(o_uPhtWr_addr), 32'd3);
    tick();

    // back-to-back same index from counter 1
    preload(7, 2'b01);
    i_upd_vld = 1'b1; i_upd_idx = IDX_W'(7); i_upd_taken = 1'b1;
    tick();
    tick();
    i_upd_vld = 1'b0;
    @(negedge i_clk);
    check("t3_k1_raddr", 32'(o_uPhtRd_addr), 32'd7);
    tick(); @(negedge i_clk);
    check("t3_k2_wvld", 32'(o_uPhtWrite_vld), 32'd1);
    check("t3_k2_cnt",  32'(o_commit_Cnt), 32'd2);
    tick(); @(negedge i_clk);
    check("t3_k3_wvld", 32'(o_uPhtWrite_vld), 32'd0);
    check("t3_k3_rvld", 32'(o_uPhtRead_vld), 32'd1);
    tick(); @(negedge i_clk);
    check("t3_k4_wvld", 32'(o_uPhtWrite_vld), 32'd1);
    check("t3_k4_cnt",  32'(o_commit_Cnt), 32'd3);
    tick(); @(negedge i_clk);
    check("t3_k5_busy", 32'(o_busy), 32'd0);
    tick();

    // starvation: predictor holds the port for 8 RD cycles
    push(9, 1'b1);
    i_pred_vld = 1'b1; i_pred_idx = IDX_W'(20);
    for (int k = 1; k <= 8; k++) begin
      tick(); @(negedge i_clk);
      check($sformatf("t4_gnt_k%0d", k), 32'(o_pred_gnt), 32'd1);
      if (k == 1) check("t4_pred_addr", 32'(o_uPhtRd_addr), 32'd20);
    end
    tick(); @(negedge i_clk);
    check("t4_k9_gnt",   32'(o_pred_gnt), 32'd0);
    check("t4_k9_raddr", 32'(o_uPhtRd_addr), 32'd9);
    check("t4_k9_wvld",  32'(o_uPhtWrite_vld), 32'd0);
    tick(); @(negedge i_clk);
    check("t4_k10_wvld", 32'(o_uPhtWrite_vld), 32'd1);
    check("t4_k10_addr", 32'(o_uPhtWr_addr), 32'd9);
    check("t4_k10_cnt",  32'(o_commit_Cnt), 32'd3);
    i_pred_vld = 1'b0;
    tick(); @(negedge i_clk);
    check("t4_k11_busy", 32'(o_busy), 32'd0);
    tick();

    // fill to full while blocked, fifth push refused
    i_pred_vld = 1'b1; i_pred_idx = '0;
    for (int i = 0; i < 4; i++) begin
      i_upd_vld = 1'b1; i_upd_idx = IDX_W'(10 + i); i_upd_taken = 1'b1;
      tick();
    end
    i_upd_idx = IDX_W'(14);
    @(negedge i_clk);
    check("t5_full_rdy", 32'(o_upd_rdy), 32'd0);
    tick();
    i_upd_vld = 1'b0; i_pred_vld = 1'b0;
    @(negedge i_clk);
    check("t5_k4_rdy", 32'(o_upd_rdy), 32'd0);
    tick(); @(negedge i_clk);
    check("t5_k5_wvld", 32'(o_uPhtWrite_vld), 32'd1);
    check("t5_k5_addr", 32'(o_uPhtWr_addr), 32'd10);
    check("t5_k5_rdy",  32'(o_upd_rdy), 32'd0);
    tick(); @(negedge i_clk);
    check("t5_k6_rdy", 32'(o_upd_rdy), 32'd1);
    for (int k = 7; k <= 11; k++) tick();
    @(negedge i_clk);
    check("t5_k11_wvld", 32'(o_uPhtWrite_vld), 32'd1);
    check("t5_k11_addr", 32'(o_uPhtWr_addr), 32'd13);
    tick(); @(negedge i_clk);
    check("t5_k12_busy", 32'(o_busy), 32'd0);
    tick();

    // flush with three queued while in RD
    i_pred_vld = 1'b1;
    for (int i = 0; i < 3; i++) begin
      i_upd_vld = 1'b1; i_upd_idx = IDX_W'(1 + i); i_upd_taken = 1'b0;
      tick();
    end
    i_upd_vld = 1'b0; i_flush = 1'b1;
    @(negedge i_clk);
    check("t6_pre_busy", 32'(o_busy), 32'd1);
    tick();
    i_flush = 1'b0; i_pred_vld = 1'b0;
    @(negedge i_clk);
    check("t6_busy", 32'(o_busy), 32'd0);
    check("t6_wvld", 32'(o_uPhtWrite_vld), 32'd0);
    check("t6_rvld", 32'(o_uPhtRead_vld), 32'd0);
    tick(); @(negedge i_clk);
    check("t6_k4_wvld", 32'(o_uPhtWrite_vld), 32'd0);
    check("t6_k4_busy", 32'(o_busy), 32'd0);
    tick();

    // async reset in the middle of WR
    push(5, 1'b1);
    tick(); tick(); @(negedge i_clk);
    check("t7_wr_vld", 32'(o_uPhtWrite_vld), 32'd1);
    #1 i_rstn = 1'b0;
    #1;
    check("t7_rst_wvld", 32'(o_uPhtWrite_vld), 32'd0);
    check("t7_rst_en",   32'(o_uPht_enable), 32'd0);
    check("t7_rst_busy", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1; i_rstn = 1'b1;
    tick(); @(negedge i_clk);
    check("t7_post_wvld", 32'(o_uPhtWrite_vld), 32'd0);
    check("t7_post_busy", 32'(o_busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
